// File: rtl/mem_vec_reader_if.sv
// Port bundle for mem_vec_reader: command/status, memory read port and output stream.
// The master modport is the reader side; slave is the environment driving it.
interface mem_vec_reader_if #(
  parameter int DWIDTH  = 16,
  parameter int MEMSIZE = 8
) ();
  logic                      start;
  logic [MEMSIZE-1:0]        base;
  logic [MEMSIZE:0]          len;
  logic                      busy;
  logic                      done;
  logic [MEMSIZE-1:0]        mem_addr;
  logic signed [DWIDTH-1:0]  mem_rdata;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DWIDTH-1:0]  out_data;
  logic                      out_last;

  modport master (
    input  start, base, len, mem_rdata, out_ready,
    output busy, done, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base, len, mem_rdata, out_ready,
    input  busy, done, mem_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_vec_reader.sv
// Streams len consecutive words from a registered-read memory port as valid/ready,
// with a 2-entry skid FIFO sized by a credit rule so captured words are never dropped.
module mem_vec_reader #(
  parameter int DWIDTH  = 16,
  parameter int MEMSIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_vec_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [MEMSIZE:0]         len_q, len_d;
  logic [MEMSIZE:0]         issued_q, issued_d;
  logic [MEMSIZE-1:0]       addr_q, addr_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;
  logic [1:0][DWIDTH-1:0]   fdata_q, fdata_d;
  logic [1:0]               flast_q, flast_d;
  logic                     head_q, head_d;
  logic [1:0]               count_q, count_d;

  logic                     pop, push, issue, wr_ptr;
  logic [MEMSIZE:0]         issued_inc;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    fdata_d    = fdata_q;
    flast_d    = flast_q;
    head_d     = head_q;
    issued_inc = issued_q + (MEMSIZE+1)'(1);

    pop    = (count_q != 2'd0) & bus.out_ready;
    push   = inflight_q;
    // count + inflight - pop < 2, rearranged to stay unsigned
    issue  = (state_q == RUN) && (issued_q < len_q) &&
             (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    inflight_d = issue;
    wr_ptr = head_q ^ count_q[0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d   = bus.base;
          len_d    = bus.len;
          issued_d = '0;
          if (bus.len == '0) done_d  = 1'b1;
          else               state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          issued_d = issued_inc;
          // addr stops on the final issued address so it holds through DRAIN
          if (issued_inc < len_q) addr_d  = addr_q + MEMSIZE'(1);
          else                    state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && flast_q[head_q]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // issued_q already counts the word being captured, so index == len-1 <=> issued == len
    if (push) begin
      fdata_d[wr_ptr] = bus.mem_rdata;
      flast_d[wr_ptr] = (issued_q == len_q);
    end
    if (pop) head_d = ~head_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      fdata_q    <= '0;
      flast_q    <= '0;
      head_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      fdata_q    <= fdata_d;
      flast_q    <= flast_d;
      head_q     <= head_d;
      count_q    <= count_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fdata_q[head_q];
  assign bus.out_last  = (count_q != 2'd0) & flast_q[head_q];

endmodule

// File: tb/tb_mem_vec_reader.sv
// Randomized scoreboard bench for mem_vec_reader: expected words are queued at start,
// a negedge monitor pops and compares on each accepted output word.
module tb_mem_vec_reader;
  localparam int DW = 16;
  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_vec_reader_if #(.DWIDTH(DW), .MEMSIZE(MS)) bus ();
  mem_vec_reader #(.DWIDTH(DW), .MEMSIZE(MS)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  logic [DW-1:0] mem [256];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  int total = 0, bad = 0;
  int cyc = 0, c0 = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  int exp_done = 0, got_done = 0, pop_cnt = 0;
  int ready_mode = 0, rp = 0;
  bit no_busy = 0;

  task automatic check(string name, int act, int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ready pattern generator, updated just after each edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = (rp % 6 == 0) || (rp % 6 == 3) || (rp % 6 == 5);
        rp++;
      end
      2: bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = $urandom_range(0, 1) != 0;
    endcase
  end

  // monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d, ed;
  logic          prev_l, el;
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", int'($unsigned(bus.out_data)), int'(prev_d));
        check("stall_last", bus.out_last, prev_l);
      end
      if (bus.done) got_done++;
      if (no_busy) begin
        check("zero_len_busy", bus.busy, 0);
        check("zero_len_valid", bus.out_valid, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_d.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %0d expected none", int'($unsigned(bus.out_data)));
        end else begin
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          check("data", int'($unsigned(bus.out_data)), int'(ed));
          check("last", bus.out_last, el);
        end
        pop_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = $unsigned(bus.out_data);
      prev_l     = bus.out_last;
    end
  end

  task automatic do_start(int b, int l, bit expect_it);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base  = 8'(b);
    bus.len   = 9'(l);
    if (expect_it) begin
      for (int k = 0; k < l; k++) begin
        exp_d.push_back(mem[(b + k) % 256]);
        exp_l.push_back(k == l - 1);
      end
      exp_done++;
    end
    @(posedge clk); #1;
    c0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(int budget, string name);
    int n = 0;
    while ((exp_d.size() != 0 || bus.busy || bus.out_valid) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_d.size());
    end
    repeat (2) @(negedge clk);
    check({name, "_done_cnt"}, got_done, exp_done);
  endtask

  initial begin
    int p, n, b, l;
    rst = 1'b1; bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_data", int'($unsigned(bus.out_data)), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    @(posedge clk); #1 rst = 1'b0;

    // basic read with cycle-exact latency and done timing
    ready_mode = 0;
    do_start(16, 4, 1);
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      if (r == 1) check("basic_first_addr", int'(bus.mem_addr), 16);
      check($sformatf("basic_valid_c%0d", r), bus.out_valid, int'(r >= 3 && r <= 6));
      check($sformatf("basic_done_c%0d", r), bus.done, int'(r == 7));
    end
    wait_idle(50, "basic");

    ready_mode = 1; rp = 0;
    do_start(16, 4, 1);
    wait_idle(100, "backpressure");

    // wrap-around address sequence
    ready_mode = 0;
    do_start(254, 4, 1);
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      check($sformatf("wrap_addr_c%0d", r), int'(bus.mem_addr), (253 + r) % 256);
    end
    wait_idle(50, "wrap");

    no_busy = 1'b1;
    do_start(5, 0, 1);
    @(negedge clk);
    check("zero_len_done", bus.done, 1);
    repeat (3) @(negedge clk);
    no_busy = 1'b0;
    wait_idle(20, "zero");

    // second start mid-run must be ignored
    ready_mode = 2;
    do_start(40, 8, 1);
    repeat (3) @(posedge clk);
    do_start(0, 2, 0);
    wait_idle(200, "busy_start");

    // reset after three accepted words
    ready_mode = 0;
    do_start(100, 8, 1);
    p = pop_cnt; n = 0;
    while (pop_cnt < p + 3 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL rst_mid_wait: got %0d pops expected 3", pop_cnt - p); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    exp_d.delete(); exp_l.delete(); exp_done--;
    @(negedge clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_done", bus.done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", got_done, exp_done);
    do_start(0, 2, 1);
    wait_idle(50, "after_rst");

    // randomized vectors over random memory contents
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      ready_mode = $urandom_range(0, 3);
      b = $urandom_range(0, 255);
      l = (t == 7) ? 300 : $urandom_range(0, 20);
      do_start(b, l, 1);
      wait_idle(4 * l + 60, "rand");
    end

    check("done_total", got_done, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
